mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ-state cycles spent waiting for mem_ack_i.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 M_i  input  2  memory control from the EX/MEM register: bit1 = MemRead, bit0 = MemWrite.
REQ-005 addr_i  input  32  data-memory address from the EX/MEM register.
REQ-006 wdata_i  input  32  store data from the EX/MEM register.
REQ-007 mem_ack_i  input  1  data memory completion strobe, one cycle per access.
REQ-008 mem_rdata_i  input  32  read data, valid only while mem_ack_i=1.
REQ-009 err_clr_i  input  1  clears the sticky timeout error.
REQ-010 mem_req_o  output  1  access request to data memory.
REQ-011 mem_we_o  output  1  write enable accompanying mem_req_o.
REQ-012 mem_addr_o  output  32  latched access address.
REQ-013 mem_wdata_o  output  32  latched store data.
REQ-014 stall_o  output  1  holds PC, IF/ID, ID/EX and EX/MEM.
REQ-015 bubble_o  output  1  zeroes the WB control entering MEM/WB; SHALL equal stall_o.
REQ-016 rdata_o  output  32  captured load data for MEM/WB.
REQ-017 rdata_valid_o  output  1  rdata_o is valid this cycle.
REQ-018 err_o  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-020 IDLE with M_i=0: stall_o=0, remain in IDLE.
REQ-021 IDLE with M_i!=0: stall_o=1 combinationally, latch addr_i/wdata_i, set mem_we_o=M_i[0], clear the wait counter, go to REQ.
REQ-022 M_i=2'b11 SHALL be treated as a write (mem_we_o=1).
REQ-023 REQ: mem_req_o=1, stall_o=1; mem_addr_o, mem_wdata_o and mem_we_o SHALL stay constant.
REQ-024 REQ with mem_ack_i=1: capture mem_rdata_i into rdata_o (write: capture 0), go to DONE.
REQ-025 REQ without ack: increment the wait counter; when the counter equals TIMEOUT-1, set err_o, load rdata_o=0 and go to DONE.
REQ-026 If ack and timeout occur in the same cycle, the ack SHALL win and err_o SHALL stay unchanged.
REQ-027 DONE: stall_o=0, mem_req_o=0, rdata_valid_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-028 DONE SHALL NOT evaluate M_i; the pipeline advances at the end of DONE, and the next access starts from IDLE.
REQ-029 Minimum access timing is one IDLE detect cycle plus one REQ cycle (both stalled), then DONE: stall_o high for 2 cycles.
REQ-030 mem_ack_i outside REQ SHALL be ignored.
REQ-031 rdata_o SHALL hold its value until the next capture.
REQ-032 The wait counter SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL NOT wrap during REQ.
REQ-033 err_o SHALL stay set until err_clr_i=1 or reset; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-034 On rst_i=1 at a clock edge, the state SHALL become IDLE and the wait counter 0.
REQ-035 On reset, outputs SHALL be: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, rdata_valid_o=0, err_o=0, stall_o=bubble_o=0 (when M_i=0).
REQ-036 Reset asserted mid-access (REQ) SHALL drop mem_req_o after that edge and discard any later ack.

Verification
REQ-037 Load: M_i=2'b10, addr_i=0x40, ack on the first REQ cycle with data 0xDEADBEEF -> stall_o high 2 cycles, then rdata_o=0xDEADBEEF with rdata_valid_o=1 for 1 cycle.
REQ-038 Store: M_i=2'b01, wdata_i=0x1234, ack after 3 REQ cycles -> mem_we_o=1, mem_wdata_o=0x1234 stable for 3 cycles, stall_o high 4 cycles, rdata_o=0.
REQ-039 Timeout: no ack, TIMEOUT=16 -> 16 REQ cycles, then DONE with err_o=1 and rdata_o=0; err_clr_i pulse -> err_o=0.
REQ-040 Back-to-back loads in consecutive EX/MEM slots -> two full IDLE-REQ-DONE sequences, no lost access, DONE never starts a request.
REQ-041 rst_i during REQ cycle 2 -> IDLE next cycle, mem_req_o=0, and an ack one cycle later does not change rdata_o.
REQ-042 Ack on the same cycle the counter reaches TIMEOUT-1 -> data captured, err_o remains 0.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Data-memory access controller for the MEM stage. Stalls the pipeline while a
// load/store is outstanding, latches the access and captures load data for MEM/WB.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        err_clr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o
);

    // A TIMEOUT of 1 still needs a one-bit counter.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              we_reg, we_next;
    logic              err_reg, err_next;
    logic              err_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        we_next       = we_reg;
        err_set       = 1'b0;
        stall_o       = 1'b0;
        mem_req_o     = 1'b0;
        rdata_valid_o = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Stall in the detect cycle itself so EX/MEM holds the access.
                if (M_i != 2'b00) begin
                    stall_o    = 1'b1;
                    addr_next  = addr_i;
                    wdata_next = wdata_i;
                    we_next    = M_i[0];
                    cnt_next   = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    rdata_next = we_reg ? 32'h0 : mem_rdata_i;
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    // Ack takes priority, so the error is only raised without one.
                    err_set    = 1'b1;
                    rdata_next = 32'h0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Pipeline advances here; M_i still shows the finished access.
                rdata_valid_o = 1'b1;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (err_set) begin
            err_next = 1'b1;
        end else if (err_clr_i) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    assign bubble_o    = stall_o;
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign rdata_o     = rdata_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomised self-checking bench for mem_stall_ctrl against a per-access
// behavioural model (latency, captured data, error flag).
module tb_mem_stall_ctrl;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  M_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_clr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        stall_o;
    logic        bubble_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    logic        model_err;
    logic [31:0] model_rdata;

    mem_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .M_i(M_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_clr_i(err_clr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .stall_o(stall_o), .bubble_o(bubble_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } exp_t;

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        int          bubble_bad;
        int          hold_bad;
        int          done_bad;
        logic        first_req;
        logic        first_stall;
        logic [31:0] rdata;
        logic        err;
        logic        we;
        bit          hung;
    } obs_t;

    // Outcome of one access: the ack lands on REQ cycle ack_at, unless that is
    // beyond the timeout window (or 0 = never), in which case the access times out.
    function automatic exp_t model_access(input logic [1:0] m, input int ack_at,
                                          input logic [31:0] data, input logic err_before);
        exp_t e;
        bit acked;
        acked          = (ack_at >= 1) && (ack_at <= TO);
        e.req_cycles   = acked ? ack_at : TO;
        e.stall_cycles = e.req_cycles + 1;
        e.we           = m[0];
        e.rdata        = (acked && !m[0]) ? data : 32'h0;
        e.err          = acked ? err_before : 1'b1;
        return e;
    endfunction

    // Drives one access from a negedge and records what the DUT did.
    task automatic run_access(input logic [1:0] m, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_at,
                              input logic [31:0] data, input bit b2b, output obs_t o);
        o = '{default: 0};
        o.hung = 1'b1;
        M_i = m; addr_i = addr; wdata_i = wdata; mem_ack_i = 1'b0;
        #1;
        if (b2b) begin
            // Still in the previous DONE: the new M_i must not start anything.
            if (stall_o || mem_req_o) o.done_bad++;
            @(negedge clk_i);
        end
        for (int cyc = 0; cyc < TO + 8; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            if (cyc == 0) begin
                o.first_req   = mem_req_o;
                o.first_stall = stall_o;
            end
            if (stall_o) o.stall_cycles++;
            if (bubble_o !== stall_o) o.bubble_bad++;
            if (mem_req_o) begin
                o.req_cycles++;
                if (mem_addr_o !== addr || mem_wdata_o !== wdata || mem_we_o !== m[0])
                    o.hold_bad++;
                addr_i      = $urandom;
                wdata_i     = $urandom;
                mem_ack_i   = (o.req_cycles == ack_at);
                mem_rdata_i = mem_ack_i ? data : $urandom;
            end else begin
                mem_ack_i = 1'b0;
            end
            if (rdata_valid_o) begin
                o.rdata = rdata_o;
                o.err   = err_o;
                o.we    = mem_we_o;
                o.hung  = 1'b0;
                break;
            end
        end
        M_i = 2'b00; mem_ack_i = 1'b0;
        n_acc++;
        $display("access %0d: M=%b addr=%h ack_at=%0d req=%0d stall=%0d rdata=%h err=%b",
                 n_acc, m, addr, ack_at, o.req_cycles, o.stall_cycles, o.rdata, o.err);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; M_i = 2'b00; addr_i = $urandom; wdata_i = $urandom;
        mem_ack_i = 1'b0; mem_rdata_i = $urandom; err_clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, stall_o, bubble_o, rdata_valid_o, err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b we=%b stall=%b bubble=%b valid=%b err=%b expected all 0",
                     mem_req_o, mem_we_o, stall_o, bubble_o, rdata_valid_o, err_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_latch: got addr=%h wdata=%h expected 0", mem_addr_o, mem_wdata_o);
        end
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", rdata_o);
        end
        rst_i = 1'b0;
        model_err = 1'b0; model_rdata = 32'h0;
        @(negedge clk_i);
        $display("reset: outputs idle");
    endtask

    task automatic test_load();
        obs_t o; exp_t e;
        e = model_access(2'b10, 1, 32'hDEADBEEF, model_err);
        run_access(2'b10, 32'h40, $urandom, 1, 32'hDEADBEEF, 1'b0, o);
        checks++;
        if (o.hung || o.stall_cycles != e.stall_cycles || o.req_cycles != e.req_cycles) begin
            errors++;
            $display("FAIL load_timing: got hung=%0d stall=%0d req=%0d expected stall=%0d req=%0d",
                     o.hung, o.stall_cycles, o.req_cycles, e.stall_cycles, e.req_cycles);
        end
        checks++;
        if (o.rdata !== e.rdata) begin
            errors++;
            $display("FAIL load_rdata: got %h expected %h", o.rdata, e.rdata);
        end
        checks++;
        if (o.hold_bad != 0 || o.bubble_bad != 0 || o.first_req !== 1'b0 || o.first_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_ctrl: got hold_bad=%0d bubble_bad=%0d first_req=%b first_stall=%b expected 0 0 0 1",
                     o.hold_bad, o.bubble_bad, o.first_req, o.first_stall);
        end
        model_rdata = e.rdata;
        @(negedge clk_i);
        checks++;
        if (rdata_valid_o !== 1'b0 || rdata_o !== model_rdata) begin
            errors++;
            $display("FAIL load_after_done: got valid=%b rdata=%h expected valid=0 rdata=%h",
                     rdata_valid_o, rdata_o, model_rdata);
        end
    endtask

    task automatic test_store();
        obs_t o; exp_t e;
        logic [1:0] ms [2];
        ms[0] = 2'b01; ms[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            e = model_access(ms[i], 3, 32'hCAFEF00D, model_err);
            run_access(ms[i], 32'h80 + 32'(i), 32'h1234, 3, 32'hCAFEF00D, 1'b0, o);
            checks++;
            if (o.hung || o.stall_cycles != e.stall_cycles || o.req_cycles != e.req_cycles) begin
                errors++;
                $display("FAIL store_timing: got stall=%0d req=%0d expected stall=%0d req=%0d",
                         o.stall_cycles, o.req_cycles, e.stall_cycles, e.req_cycles);
            end
            checks++;
            if (o.we !== e.we || o.rdata !== e.rdata || o.hold_bad != 0) begin
                errors++;
                $display("FAIL store_data: got we=%b rdata=%h hold_bad=%0d expected we=%b rdata=%h hold_bad=0",
                         o.we, o.rdata, o.hold_bad, e.we, e.rdata);
            end
            model_rdata = e.rdata;
            @(negedge clk_i);
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        model_rdata = 32'h5A5A5A5A;
        e = model_access(2'b10, 2, model_rdata, model_err);
        run_access(2'b10, 32'h100, 32'h0, 2, model_rdata, 1'b0, o);
        @(negedge clk_i);
        e = model_access(2'b10, 0, 32'h0, model_err);
        run_access(2'b10, 32'h104, 32'h0, 0, 32'h0, 1'b0, o);
        checks++;
        if (o.hung || o.req_cycles != e.req_cycles || o.stall_cycles != e.stall_cycles) begin
            errors++;
            $display("FAIL timeout_timing: got hung=%0d req=%0d stall=%0d expected req=%0d stall=%0d",
                     o.hung, o.req_cycles, o.stall_cycles, e.req_cycles, e.stall_cycles);
        end
        checks++;
        if (o.err !== e.err || o.rdata !== e.rdata) begin
            errors++;
            $display("FAIL timeout_result: got err=%b rdata=%h expected err=%b rdata=%h",
                     o.err, o.rdata, e.err, e.rdata);
        end
        model_err = e.err; model_rdata = e.rdata;
        repeat (3) @(negedge clk_i);
        checks++;
        if (err_o !== model_err) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b expected %b", err_o, model_err);
        end
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        model_err = 1'b0;
        checks++;
        if (err_o !== model_err) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b expected %b", err_o, model_err);
        end
    endtask

    task automatic test_set_wins();
        obs_t o; exp_t e;
        err_clr_i = 1'b1;
        e = model_access(2'b01, 0, 32'h0, model_err);
        run_access(2'b01, 32'h200, 32'h77, 0, 32'h0, 1'b0, o);
        checks++;
        if (o.hung || o.err !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got hung=%0d err=%b expected err=1", o.hung, o.err);
        end
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_set: got err=%b expected 0", err_o);
        end
        err_clr_i = 1'b0;
        model_err = 1'b0; model_rdata = e.rdata;
    endtask

    task automatic test_ack_at_timeout();
        obs_t o; exp_t e;
        e = model_access(2'b10, TO, 32'hA5A50FF0, model_err);
        run_access(2'b10, 32'h300, 32'h0, TO, 32'hA5A50FF0, 1'b0, o);
        checks++;
        if (o.hung || o.req_cycles != e.req_cycles || o.rdata !== e.rdata || o.err !== e.err) begin
            errors++;
            $display("FAIL ack_at_timeout: got req=%0d rdata=%h err=%b expected req=%0d rdata=%h err=%b",
                     o.req_cycles, o.rdata, o.err, e.req_cycles, e.rdata, e.err);
        end
        model_rdata = e.rdata; model_err = e.err;
        @(negedge clk_i);
    endtask

    task automatic test_ack_ignored();
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = 1'b1; mem_rdata_i = $urandom;
            @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        checks++;
        if (rdata_o !== model_rdata || stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_ignored: got rdata=%h stall=%b req=%b valid=%b expected rdata=%h and 0 0 0",
                     rdata_o, stall_o, mem_req_o, rdata_valid_o, model_rdata);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; exp_t e1, e2;
        e1 = model_access(2'b10, 1, 32'h11112222, model_err);
        run_access(2'b10, 32'h400, 32'h0, 1, 32'h11112222, 1'b0, o1);
        e2 = model_access(2'b10, 2, 32'h33334444, model_err);
        run_access(2'b10, 32'h404, 32'h0, 2, 32'h33334444, 1'b1, o2);
        checks++;
        if (o1.hung || o1.rdata !== e1.rdata || o1.stall_cycles != e1.stall_cycles) begin
            errors++;
            $display("FAIL b2b_first: got rdata=%h stall=%0d expected rdata=%h stall=%0d",
                     o1.rdata, o1.stall_cycles, e1.rdata, e1.stall_cycles);
        end
        checks++;
        if (o2.hung || o2.rdata !== e2.rdata || o2.stall_cycles != e2.stall_cycles || o2.req_cycles != e2.req_cycles) begin
            errors++;
            $display("FAIL b2b_second: got rdata=%h stall=%0d req=%0d expected rdata=%h stall=%0d req=%0d",
                     o2.rdata, o2.stall_cycles, o2.req_cycles, e2.rdata, e2.stall_cycles, e2.req_cycles);
        end
        checks++;
        if (o2.done_bad != 0 || o2.first_req !== 1'b0 || o2.hold_bad != 0) begin
            errors++;
            $display("FAIL b2b_done_start: got done_bad=%0d first_req=%b hold_bad=%0d expected 0 0 0",
                     o2.done_bad, o2.first_req, o2.hold_bad);
        end
        model_rdata = e2.rdata;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_access();
        M_i = 2'b10; addr_i = 32'h500; wdata_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b expected 1", mem_req_o);
        end
        rst_i = 1'b1; M_i = 2'b00;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: got req=%b stall=%b expected 0 0", mem_req_o, stall_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        model_rdata = 32'h0; model_err = 1'b0;
        checks++;
        if (rdata_o !== model_rdata || rdata_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_ack: got rdata=%h valid=%b expected %h 0",
                     rdata_o, rdata_valid_o, model_rdata);
        end
        $display("reset mid-access: request dropped");
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        int r, ack_at, g;
        logic [1:0] m;
        logic [31:0] data;
        bit b2b, clr;
        b2b = 1'b0;
        for (int it = 0; it < 40; it++) begin
            m = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            ack_at = (r < 6) ? $urandom_range(1, 4) : (r < 8) ? $urandom_range(5, TO) : (r == 8) ? 0 : TO + 1;
            data = $urandom;
            e = model_access(m, ack_at, data, model_err);
            run_access(m, $urandom, $urandom, ack_at, data, b2b, o);
            checks++;
            if (o.hung || o.req_cycles != e.req_cycles || o.stall_cycles != e.stall_cycles ||
                o.first_req !== 1'b0 || o.done_bad != 0) begin
                errors++;
                $display("FAIL rand_timing: got hung=%0d req=%0d stall=%0d first_req=%b done_bad=%0d expected req=%0d stall=%0d",
                         o.hung, o.req_cycles, o.stall_cycles, o.first_req, o.done_bad, e.req_cycles, e.stall_cycles);
            end
            checks++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.we !== e.we) begin
                errors++;
                $display("FAIL rand_result: got rdata=%h err=%b we=%b expected rdata=%h err=%b we=%b",
                         o.rdata, o.err, o.we, e.rdata, e.err, e.we);
            end
            checks++;
            if (o.hold_bad != 0 || o.bubble_bad != 0) begin
                errors++;
                $display("FAIL rand_hold: got hold_bad=%0d bubble_bad=%0d expected 0 0", o.hold_bad, o.bubble_bad);
            end
            model_rdata = e.rdata; model_err = e.err;
            g = $urandom_range(0, 2);
            b2b = (g == 0);
            for (int k = 0; k < g; k++) begin
                clr = ($urandom_range(0, 3) == 0);
                err_clr_i = clr;
                @(negedge clk_i);
                err_clr_i = 1'b0;
                if (clr) model_err = 1'b0;
                checks++;
                if (stall_o !== 1'b0 || err_o !== model_err || rdata_o !== model_rdata || rdata_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle: got stall=%b err=%b rdata=%h valid=%b expected 0 %b %h 0",
                             stall_o, err_o, rdata_o, rdata_valid_o, model_err, model_rdata);
                end
            end
        end
        if (b2b) @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_set_wins();
        test_ack_at_timeout();
        test_ack_ignored();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
